fwd_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the pipeline's RAW forwarding logic. Tracks in-flight register writes in
//  an internal shift-register scoreboard instead of taking per-stage Rw/RegWrite inputs. Produces a

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_hazard_scoreboard_if.sv | 29 ++
 rtl/fwd_hazard_scoreboard_src_match.sv | 46 ++++
 rtl/fwd_hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
// Optional statistics ports are enabled with the FWD_STATS_EN macro.
package fwd_pkg;

  // The stored register field is wide enough for any REG_AW up to this limit.
  localparam int SB_RW_W    = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RW_W-1:0] rw;
    logic               regwrite;
    logic               is_load;
  } sb_entry_t;

  function automatic int fwd_selw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-stage request and forwarding/stall response bundle for fwd_hazard_scoreboard.
interface fwd_hazard_scoreboard_if #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5
);
  localparam int SELW = fwd_pkg::fwd_selw(NUM_STAGES);

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_use_src;
  logic [REG_AW-1:0]         id_rw;
  logic                      id_regwrite;
  logic                      id_is_load;
  logic                      flush;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall;

  modport master (
    output id_valid, id_src, id_use_src, id_rw, id_regwrite, id_is_load, flush,
    input  fwd_sel, stall
  );

  modport slave (
    input  id_valid, id_src, id_use_src, id_rw, id_regwrite, id_is_load, flush,
    output fwd_sel, stall
  );

endinterface

// File: rtl/fwd_hazard_scoreboard_src_match.sv
// One ID source operand checked against the scoreboard: youngest-match select plus load-use flag.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 1,
  parameter int SELW       = fwd_selw(NUM_STAGES)
) (
  input  sb_entry_t         sb [NUM_STAGES],
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              id_valid,
  output logic [SELW-1:0]   sel,
  output logic              load_use
);

  logic            hit;
  logic            hit_load;
  logic [SELW-1:0] hit_stage;

  // Scan oldest to youngest so the lowest stage number overwrites any older match.
  always_comb begin
    hit       = 1'b0;
    hit_load  = 1'b0;
    hit_stage = '0;
    sel       = SELW'(FWD_SEL_RF);
    load_use  = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (sb[k].valid && sb[k].regwrite && (sb[k].rw == SB_RW_W'(src)) &&
          (src != '0) && use_src && id_valid) begin
        hit       = 1'b1;
        hit_load  = sb[k].is_load;
        hit_stage = SELW'(k + 1);
      end
    end
    if (hit) begin
      if (hit_load && (int'(hit_stage) <= LOAD_LAT)) begin
        load_use = 1'b1;
      end else begin
        sel = hit_stage;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// RAW forwarding select and load-use stall driven by an internal in-flight write scoreboard.
// Defining FWD_STATS_EN adds saturating stall/forward event counters as extra output ports.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fwd_hazard_scoreboard_if.slave  bus
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]             stat_stall_cycles,
  output logic [31:0]             stat_fwd_events
`endif
);

  localparam int SELW = fwd_selw(NUM_STAGES);

  sb_entry_t               sb_q [NUM_STAGES];
  sb_entry_t               sb_d [NUM_STAGES];
  logic [NUM_SRC-1:0]      load_use;
  logic [NUM_SRC*SELW-1:0] fwd_sel;
  logic                    stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .NUM_STAGES (NUM_STAGES),
      .REG_AW     (REG_AW),
      .LOAD_LAT   (LOAD_LAT),
      .SELW       (SELW)
    ) u_match (
      .sb       (sb_q),
      .src      (bus.id_src[i*REG_AW +: REG_AW]),
      .use_src  (bus.id_use_src[i]),
      .id_valid (bus.id_valid),
      .sel      (fwd_sel[i*SELW +: SELW]),
      .load_use (load_use[i])
    );
  end

  // A flushed instruction is discarded anyway, so it must never hold the front end.
  assign stall       = (|load_use) && !bus.flush;
  assign bus.stall   = stall;
  assign bus.fwd_sel = fwd_sel;

  always_comb begin
    sb_d[0] = '0;
    if (bus.id_valid && !stall && !bus.flush) begin
      sb_d[0].valid    = 1'b1;
      sb_d[0].rw       = SB_RW_W'(bus.id_rw);
      sb_d[0].regwrite = bus.id_regwrite;
      sb_d[0].is_load  = bus.id_is_load;
    end
    for (int k = 1; k < NUM_STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stat_stall_q;
  logic [31:0] stat_stall_d;
  logic [31:0] stat_fwd_q;
  logic [31:0] stat_fwd_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_fwd_d   = stat_fwd_q;
    if (stall && !(&stat_stall_q)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
    if ((|fwd_sel) && !stall && !(&stat_fwd_q)) begin
      stat_fwd_d = stat_fwd_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q <= '0;
      stat_fwd_q   <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_fwd_q   <= stat_fwd_d;
    end
  end

  assign stat_stall_cycles = stat_stall_q;
  assign stat_fwd_events   = stat_fwd_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed table-driven bench for fwd_hazard_scoreboard (default config plus a 5-stage/LOAD_LAT=2 instance).
module tb_fwd_hazard_scoreboard;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fwd_hazard_scoreboard_if #(.NUM_STAGES(3), .NUM_SRC(2), .REG_AW(5)) bus1 ();
  fwd_hazard_scoreboard_if #(.NUM_STAGES(5), .NUM_SRC(3), .REG_AW(5)) bus2 ();

`ifdef FWD_STATS_EN
  logic [31:0] st1_stall;
  logic [31:0] st1_fwd;
  logic [31:0] st2_stall;
  logic [31:0] st2_fwd;
`endif

  fwd_hazard_scoreboard #(.NUM_STAGES(3), .NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef FWD_STATS_EN
    ,
    .stat_stall_cycles (st1_stall),
    .stat_fwd_events   (st1_fwd)
`endif
  );

  fwd_hazard_scoreboard #(.NUM_STAGES(5), .NUM_SRC(3), .REG_AW(5), .LOAD_LAT(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
`ifdef FWD_STATS_EN
    ,
    .stat_stall_cycles (st2_stall),
    .stat_fwd_events   (st2_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       vld;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] use_src;
    logic [4:0] rw;
    logic       wr;
    logic       ld;
    logic       fl;
    int         e0;
    int         e1;
    int         est;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic vld, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] use_src, input logic [4:0] rw, input logic wr, input logic ld,
                        input logic fl, input int e0, input int e1, input int est);
    vec_t v;
    v.name = name; v.vld = vld; v.s0 = s0; v.s1 = s1; v.use_src = use_src; v.rw = rw;
    v.wr = wr; v.ld = ld; v.fl = fl; v.e0 = e0; v.e1 = e1; v.est = est;
    vecs.push_back(v);
  endtask

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) addVec("idle", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus1.id_valid    = v.vld;
    bus1.id_src      = {v.s1, v.s0};
    bus1.id_use_src  = v.use_src;
    bus1.id_rw       = v.rw;
    bus1.id_regwrite = v.wr;
    bus1.id_is_load  = v.ld;
    bus1.flush       = v.fl;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic checkDut1(input string name, input int e0, input int e1, input int est);
    checkOutput({name, ".sel0"},  int'(bus1.fwd_sel[1:0]), e0);
    checkOutput({name, ".sel1"},  int'(bus1.fwd_sel[3:2]), e1);
    checkOutput({name, ".stall"}, int'(bus1.stall), est);
  endtask

  task automatic idleBus2();
    bus2.id_valid    = 1'b0;
    bus2.id_src      = '0;
    bus2.id_use_src  = '0;
    bus2.id_rw       = '0;
    bus2.id_regwrite = 1'b0;
    bus2.id_is_load  = 1'b0;
    bus2.flush       = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   stall_cnt;
    checks = 0;
    errors = 0;

    // add $3,$1,$2 ; sub $4,$3,$5
    addVec("t1_add",  1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0);
    addVec("t1_sub",  1, 3, 5, 2'b11, 4, 1, 0, 0, 1, 0, 0);
    addIdle(3);
    // lw $3 ; add $4,$3,$3 (stall once, then MEM forward) ; add $6,$4,$3
    addVec("t2_lw",    1, 1, 3, 2'b01, 3, 1, 1, 0, 0, 0, 0);
    addVec("t2_stall", 1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0, 1);
    addVec("t2_fwd",   1, 3, 3, 2'b11, 4, 1, 0, 0, 2, 2, 0);
    addVec("t2_wb",    1, 4, 3, 2'b11, 6, 1, 0, 0, 1, 3, 0);
    addIdle(3);
    // add $3 ; add $3 ; add $6,$3,$0
    addVec("t3_a",     1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0);
    addVec("t3_b",     1, 4, 5, 2'b11, 3, 1, 0, 0, 0, 0, 0);
    addVec("t3_young", 1, 3, 0, 2'b11, 6, 1, 0, 0, 1, 0, 0);
    addIdle(3);
    // addi $0,$1,5 ; add $2,$0,$0 ; ori $9,$2,imm (rt=$2 unused)
    addVec("t4_addi",  1, 1, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0);
    addVec("t4_r0",    1, 0, 0, 2'b11, 2, 1, 0, 0, 0, 0, 0);
    addVec("t4_nouse", 1, 2, 2, 2'b01, 9, 1, 0, 0, 1, 0, 0);
    addIdle(3);
    // lw $3 ; add $4,$3,$1 flushed ; add $5,$4,$3 proves the flushed slot became a bubble
    addVec("t5_lw",     1, 1, 3, 2'b01, 3, 1, 1, 0, 0, 0, 0);
    addVec("t5_flush",  1, 3, 1, 2'b11, 4, 1, 0, 1, 0, 0, 0);
    addVec("t5_bubble", 1, 4, 3, 2'b11, 5, 1, 0, 0, 0, 2, 0);
    addVec("t5_novld",  0, 5, 5, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    addIdle(3);

    v.name = "init"; v.vld = 0; v.s0 = 0; v.s1 = 0; v.use_src = 0; v.rw = 0;
    v.wr = 0; v.ld = 0; v.fl = 0; v.e0 = 0; v.e1 = 0; v.est = 0;
    applyStimulus(v);
    idleBus2();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkDut1("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkDut1(vecs[i].name, vecs[i].e0, vecs[i].e1, vecs[i].est);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset while a load-use stall is being signalled
    v.name = "rs_lw"; v.vld = 1; v.s0 = 1; v.s1 = 3; v.use_src = 2'b01; v.rw = 3; v.wr = 1; v.ld = 1;
    applyStimulus(v);
    @(posedge clk);
    #1;
    v.name = "rs_use"; v.s0 = 3; v.s1 = 3; v.use_src = 2'b11; v.rw = 4; v.ld = 0;
    applyStimulus(v);
    @(negedge clk);
    checkDut1("rs_pre", 0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    checkDut1("rs_async", 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkDut1("rs_after", 0, 0, 0);
    @(posedge clk);
    #1;
    v.vld = 0;
    applyStimulus(v);

    // Deep pipe: lw $7 then use $7 stalls two cycles, then forwards from stage 3
    bus2.id_valid    = 1'b1;
    bus2.id_src      = {5'd0, 5'd0, 5'd1};
    bus2.id_use_src  = 3'b001;
    bus2.id_rw       = 5'd7;
    bus2.id_regwrite = 1'b1;
    bus2.id_is_load  = 1'b1;
    @(negedge clk);
    checkOutput("t6_lw.stall", int'(bus2.stall), 0);
    @(posedge clk);
    #1;
    bus2.id_src      = {5'd0, 5'd0, 5'd7};
    bus2.id_rw       = 5'd8;
    bus2.id_is_load  = 1'b0;
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!bus2.stall) break;
      stall_cnt++;
      checkOutput("t6_stall.sel0", int'(bus2.fwd_sel[2:0]), 0);
      @(posedge clk);
      #1;
    end
    checkOutput("t6_stall_cycles", stall_cnt, 2);
    checkOutput("t6_fwd.stall", int'(bus2.stall), 0);
    checkOutput("t6_fwd.sel0", int'(bus2.fwd_sel[2:0]), 3);
    checkOutput("t6_fwd.sel1", int'(bus2.fwd_sel[5:3]), 0);
    checkOutput("t6_fwd.sel2", int'(bus2.fwd_sel[8:6]), 0);
    @(posedge clk);
    #1;
    idleBus2();
    @(negedge clk);
`ifdef FWD_STATS_EN
    checkOutput("t6_stat_stall", int'(st2_stall), 2);
    checkOutput("t6_stat_fwd", int'(st2_fwd), 1);
`endif
    checkOutput("t6_idle.stall", int'(bus2.stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
